sram_stream_ctrl: RTL and testbench

- Sequencing front-end for the single-port SRAM macro: moves a burst of words from an upstream valid/ready stream into consecutive SRAM addresses, or reads a burst back out onto a downstream valid/ready stream.
- Owns the SRAM's chip-select, write-enable and address. Absorbs the macro's 1-cycle registered read latency with a 2-entry output buffer, so downstream backpressure never drops data.

---
 rtl/sram_stream_ctrl_if.sv | 34 +++
 rtl/sram_stream_ctrl.sv | 101 ++++++++++
 tb/tb_sram_stream_ctrl.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/sram_stream_ctrl_if.sv
// sram_stream_ctrl_if: command, stream and SRAM-macro signals of sram_stream_ctrl.
// The slave modport is the controller's view; master is the surrounding system.
interface sram_stream_ctrl_if #(
    parameter int SRAM_DEPTH = 10,
    parameter int DATA_WIDTH = 16
);
    localparam int AW = $clog2(SRAM_DEPTH);
    localparam int LW = $clog2(SRAM_DEPTH + 1);
    logic                  iStart;
    logic                  iMode;
    logic [AW-1:0]         iBase;
    logic [LW-1:0]         iLen;
    logic                  oBusy;
    logic                  oDone;
    logic                  iInVld;
    logic                  oInRdy;
    logic [DATA_WIDTH-1:0] iInDt;
    logic                  oOutVld;
    logic                  iOutRdy;
    logic [DATA_WIDTH-1:0] oOutDt;
    logic                  oCsn;
    logic                  oWrn;
    logic [AW-1:0]         oAddr;
    logic [DATA_WIDTH-1:0] oWrDt;
    logic [DATA_WIDTH-1:0] iRdDt;
    modport slave (
        input  iStart, iMode, iBase, iLen, iInVld, iInDt, iOutRdy, iRdDt,
        output oBusy, oDone, oInRdy, oOutVld, oOutDt, oCsn, oWrn, oAddr, oWrDt
    );
    modport master (
        output iStart, iMode, iBase, iLen, iInVld, iInDt, iOutRdy, iRdDt,
        input  oBusy, oDone, oInRdy, oOutVld, oOutDt, oCsn, oWrn, oAddr, oWrDt
    );
endinterface

// File: rtl/sram_stream_ctrl.sv
// sram_stream_ctrl: bursts a valid/ready stream into or out of a single-port SRAM,
// hiding the macro's 1-cycle read latency behind a 2-entry output FIFO.
module sram_stream_ctrl #(
    parameter int SRAM_DEPTH = 10,
    parameter int DATA_WIDTH = 16
) (
    input logic               iClk,
    input logic               iRsn,
    sram_stream_ctrl_if.slave bus
);
    localparam int AW = $clog2(SRAM_DEPTH);
    localparam int LW = $clog2(SRAM_DEPTH + 1);

    typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} state_t;

    state_t                state_q, state_d;
    logic [AW-1:0]         addr_q, addr_d, last_addr_q, last_addr_d;
    logic [DATA_WIDTH-1:0] last_wdt_q, last_wdt_d;
    logic [LW-1:0]         len_q, len_d, cnt_q, cnt_d;
    logic                  inflight_q;
    logic [DATA_WIDTH-1:0] fifo_q [2];
    logic                  wptr_q, rptr_q;
    logic [1:0]            count_q, count_d;
    logic                  wr, rd, pop, cap;
    logic [LW-1:0]         eff_len;
    logic [AW-1:0]         base, addr_inc;

    always_comb begin
        eff_len = (bus.iLen > LW'(SRAM_DEPTH)) ? LW'(SRAM_DEPTH) : bus.iLen;
        base = (int'(bus.iBase) >= SRAM_DEPTH) ? bus.iBase - AW'(SRAM_DEPTH) : bus.iBase;
        addr_inc = (addr_q == AW'(SRAM_DEPTH - 1)) ? '0 : addr_q + 1'b1;
        pop = (count_q != 2'd0) && bus.iOutRdy;
        cap = inflight_q;
        wr = (state_q == WRITE) && bus.iInVld;
        // a read may only issue if its word is guaranteed a FIFO slot on return
        rd = (state_q == READ) && (cnt_q < len_q) &&
             (({1'b0, count_q} + {2'b0, inflight_q}) < (3'd2 + {2'b0, pop}));
        count_d = count_q + {1'b0, cap} - {1'b0, pop};
    end

    always_comb begin
        state_d = state_q;
        addr_d = (wr || rd) ? addr_inc : addr_q;
        cnt_d = (wr || rd) ? cnt_q + 1'b1 : cnt_q;
        len_d = len_q;
        last_addr_d = (wr || rd) ? addr_q : last_addr_q;
        last_wdt_d = wr ? bus.iInDt : last_wdt_q;
        case (state_q)
            IDLE: if (bus.iStart) begin
                addr_d = base;
                len_d = eff_len;
                cnt_d = '0;
                state_d = (eff_len == '0) ? DONE : (bus.iMode ? READ : WRITE);
            end
            WRITE: if (wr && (cnt_q + 1'b1 == len_q)) state_d = DONE;
            READ: if ((cnt_q == len_q) && !inflight_q && (count_d == 2'd0)) state_d = DONE;
            DONE: state_d = IDLE;
        endcase
    end

    always_ff @(posedge iClk or negedge iRsn) begin
        if (!iRsn) begin
            state_q <= IDLE;
            addr_q <= '0;
            last_addr_q <= '0;
            last_wdt_q <= '0;
            len_q <= '0;
            cnt_q <= '0;
            inflight_q <= 1'b0;
            fifo_q <= '{default: '0};
            wptr_q <= 1'b0;
            rptr_q <= 1'b0;
            count_q <= 2'd0;
        end else begin
            state_q <= state_d;
            addr_q <= addr_d;
            last_addr_q <= last_addr_d;
            last_wdt_q <= last_wdt_d;
            len_q <= len_d;
            cnt_q <= cnt_d;
            inflight_q <= rd;
            if (cap) fifo_q[wptr_q] <= bus.iRdDt;
            wptr_q <= wptr_q ^ cap;
            rptr_q <= rptr_q ^ pop;
            count_q <= count_d;
        end
    end

    assign bus.oBusy = (state_q != IDLE);
    assign bus.oDone = (state_q == DONE);
    assign bus.oInRdy = (state_q == WRITE);
    assign bus.oOutVld = (count_q != 2'd0);
    assign bus.oOutDt = fifo_q[rptr_q];
    assign bus.oCsn = !(wr || rd);
    assign bus.oWrn = wr;
    assign bus.oAddr = (wr || rd) ? addr_q : last_addr_q;
    assign bus.oWrDt = wr ? bus.iInDt : last_wdt_q;

    a_no_overflow: assert property (@(posedge iClk) disable iff (!iRsn)
        !((count_q == 2'd2) && cap && !pop));
endmodule

// File: tb/tb_sram_stream_ctrl.sv
// tb_sram_stream_ctrl: directed bursts against an SRAM model; a negedge monitor
// checks every SRAM access and every popped word against scoreboard queues.
module tb_sram_stream_ctrl;
    localparam int DEPTH = 10;
    localparam int DW = 16;

    typedef struct packed {
        logic          wr;
        logic [3:0]    addr;
        logic [DW-1:0] data;
    } acc_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sram_stream_ctrl_if #(.SRAM_DEPTH(DEPTH), .DATA_WIDTH(DW)) bus();
    sram_stream_ctrl #(.SRAM_DEPTH(DEPTH), .DATA_WIDTH(DW)) dut (
        .iClk(clk),
        .iRsn(rst_n),
        .bus (bus.slave)
    );

    acc_t          acc_q[$];
    logic [DW-1:0] out_q[$];
    logic [DW-1:0] mem [16];
    logic [DW-1:0] ref_mem [16];
    logic          seeded = 1'b0;
    logic          vld_pat [8];
    logic          rdy_pat [8];
    logic [DW-1:0] wdata [16];
    logic          poke_start = 1'b0;
    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    int pops = 0;
    int last_evt_cyc = 0;
    int first_vld_cyc = -1;
    int start_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // SRAM macro model: registered read, contents survive controller reset
    always @(posedge clk) begin
        if (!seeded) begin
            for (int i = 0; i < 16; i++) mem[i] <= DW'(16'h5000 + i);
            seeded <= 1'b1;
        end else if (!bus.oCsn) begin
            if (bus.oWrn) mem[bus.oAddr] <= bus.oWrDt;
            else bus.iRdDt <= mem[bus.oAddr];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (!bus.oCsn) begin : mon_acc
                acc_t e;
                check("addr_in_range", 32'(bus.oAddr < 4'(DEPTH)), 1);
                check("access_expected", 32'(acc_q.size() > 0), 1);
                if (acc_q.size() > 0) begin
                    e = acc_q.pop_front();
                    check("acc_is_write", bus.oWrn, e.wr);
                    check("acc_addr", bus.oAddr, e.addr);
                    if (e.wr) check("acc_wdata", bus.oWrDt, e.data);
                end
                last_evt_cyc = cyc;
            end
            if (bus.oOutVld && first_vld_cyc < 0) first_vld_cyc = cyc;
            if (bus.oOutVld && bus.iOutRdy) begin
                check("out_expected", 32'(out_q.size() > 0), 1);
                if (out_q.size() > 0) check("out_data", bus.oOutDt, out_q.pop_front());
                pops++;
                last_evt_cyc = cyc;
            end
        end
    end

    task automatic run_burst(input logic mode, input int base, input int len, input int abort_after);
        int   n, wi;
        logic acc, done;
        acc_t e;
        n = (len > DEPTH) ? DEPTH : len;
        for (int k = 0; k < n; k++) begin
            int a;
            a = (base + k) % DEPTH;
            e.wr = !mode;
            e.addr = 4'(a);
            e.data = mode ? '0 : wdata[k];
            acc_q.push_back(e);
            if (mode) out_q.push_back(ref_mem[a]);
            else ref_mem[a] = wdata[k];
        end
        pops = 0;
        first_vld_cyc = -1;
        wi = 0;
        done = 1'b0;
        bus.iStart = 1'b1;
        bus.iMode = mode;
        bus.iBase = 4'(base);
        bus.iLen = 4'(len);
        @(posedge clk);
        #1;
        start_cyc = cyc;
        for (int c = 0; c < 400 && !done; c++) begin
            bus.iStart = poke_start && (c == 3);
            bus.iInVld = !mode && (wi < n) && vld_pat[c % 8];
            bus.iInDt = wdata[wi % 16];
            bus.iOutRdy = mode && rdy_pat[c % 8];
            @(negedge clk);
            acc = bus.iInVld && bus.oInRdy;
            if (bus.oDone) begin
                done = 1'b1;
                check("done_cycle", cyc, (n == 0) ? start_cyc : last_evt_cyc + 1);
            end
            @(posedge clk);
            #1;
            if (acc) wi++;
            if (abort_after > 0 && pops >= abort_after) begin
                #2 rst_n = 1'b0;
                #1;
                check("rst_outvld", bus.oOutVld, 0);
                check("rst_csn", bus.oCsn, 1);
                check("rst_busy", bus.oBusy, 0);
                check("rst_done", bus.oDone, 0);
                acc_q.delete();
                out_q.delete();
                bus.iOutRdy = 1'b0;
                bus.iStart = 1'b0;
                repeat (2) @(posedge clk);
                #3 rst_n = 1'b1;
                repeat (3) begin
                    @(negedge clk);
                    check("no_done_after_abort", bus.oDone, 0);
                    check("idle_after_abort", bus.oBusy, 0);
                end
                @(posedge clk);
                #1;
                return;
            end
        end
        check("done_seen", done, 1);
        bus.iStart = 1'b0;
        bus.iInVld = 1'b0;
        bus.iOutRdy = 1'b0;
        @(negedge clk);
        check("done_one_cycle", bus.oDone, 0);
        check("idle_after_done", bus.oBusy, 0);
        check("acc_q_drained", acc_q.size(), 0);
        check("out_q_drained", out_q.size(), 0);
        if (mode && n > 0) check("first_vld_latency", first_vld_cyc - start_cyc, 2);
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.iStart = 1'b0;
        bus.iMode = 1'b0;
        bus.iBase = '0;
        bus.iLen = '0;
        bus.iInVld = 1'b0;
        bus.iInDt = '0;
        bus.iOutRdy = 1'b0;
        for (int i = 0; i < 16; i++) begin
            ref_mem[i] = DW'(16'h5000 + i);
            wdata[i] = '0;
        end
        vld_pat = '{8{1'b1}};
        rdy_pat = '{8{1'b1}};
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy0", bus.oBusy, 0);
        check("rst_done0", bus.oDone, 0);
        check("rst_inrdy0", bus.oInRdy, 0);
        check("rst_outvld0", bus.oOutVld, 0);
        check("rst_outdt0", bus.oOutDt, 0);
        check("rst_csn0", bus.oCsn, 1);
        check("rst_wrn0", bus.oWrn, 0);
        check("rst_addr0", bus.oAddr, 0);
        check("rst_wrdt0", bus.oWrDt, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) wdata[k] = DW'(16'hA001 + k);
        run_burst(1'b0, 2, 4, 0);
        run_burst(1'b1, 2, 4, 0);
        vld_pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        for (int k = 0; k < 4; k++) wdata[k] = DW'(16'hB001 + k);
        run_burst(1'b0, 8, 4, 0);
        run_burst(1'b1, 8, 4, 0);
        rdy_pat = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        run_burst(1'b1, 0, 6, 0);
        rdy_pat = '{8{1'b1}};
        vld_pat = '{8{1'b1}};
        run_burst(1'b0, 3, 0, 0);
        poke_start = 1'b1;
        run_burst(1'b1, 3, 15, 0);
        poke_start = 1'b0;
        run_burst(1'b1, 2, 5, 2);
        wdata[0] = 16'hC001;
        wdata[1] = 16'hC002;
        run_burst(1'b0, 6, 2, 0);
        run_burst(1'b1, 5, 3, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
